core_wb_bridge: RTL and testbench

Bus bridge between the core's native memory request port and the classic Wishbone master port that the Controller consumes. It turns level-held core read/write requests into single, well-formed Wishbone classic cycles, with `cyc`/`stb` asserted only while a transfer is outstanding. It returns the slave's data and ack to the core, and it bounds every cycle with a timeout that produces an error response. It sits directly downstream of the core and upstream of the Controller and data memory, replacing tied-high `cyc`/`stb`.

---
 rtl/core_wb_bridge.sv | 152 +++++++++++++++
 tb/tb_core_wb_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/core_wb_bridge.sv
// core_wb_bridge: core request port to Wishbone classic master, with timeout error responses.
// Define CORE_WB_BRIDGE_RSP_REG_EN to register the core response (adds a RESP state, +1 cycle latency).
module core_wb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int SEL_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_rd_i,
    input  logic                  req_wr_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic [SEL_WIDTH-1:0]  req_sel_i,
    output logic                  rsp_ack_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic [7:0]            err_count_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  wb_ack_i
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = TIMEOUT_CYCLES != 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef CORE_WB_BRIDGE_RSP_REG_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_RESP = 2'd2} state_e;
    localparam state_e S_AFTER = S_RESP;
`else
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;
    localparam state_e S_AFTER = S_IDLE;
`endif
    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic                    cyc_q, cyc_d;
    logic                    busy_q, busy_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic                    req, accept, in_active, acked, timed_out, done;
    logic [DATA_WIDTH-1:0]   rsp_data_w;

    always_comb begin
        req        = req_rd_i | req_wr_i;
        accept     = (state_q == S_IDLE) && req;
        in_active  = state_q == S_ACTIVE;
        acked      = in_active && wb_ack_i;
        // ack on the very last allowed cycle takes precedence over the timeout
        timed_out  = TO_EN && in_active && !wb_ack_i && (cnt_q == CNT_LAST);
        done       = acked || timed_out;
        rsp_data_w = acked ? (we_q ? '0 : wb_data_i) : timed_out ? ERR_DATA : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = (state_q == S_IDLE)   ? (req ? S_ACTIVE : S_IDLE) :
                  (state_q == S_ACTIVE) ? (done ? S_AFTER : S_ACTIVE) : S_IDLE;
    end

    always_comb begin
        we_d      = accept ? req_wr_i : we_q;
        addr_d    = accept ? req_addr_i : addr_q;
        wdata_d   = accept ? req_data_i : wdata_q;
        sel_d     = accept ? req_sel_i : sel_q;
        cnt_d     = accept ? '0 : (in_active && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        err_cnt_d = (timed_out && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        cyc_d     = state_d == S_ACTIVE;
        busy_d    = state_d != S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            cyc_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            cyc_q     <= cyc_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign wb_sel_o    = sel_q;
    assign busy_o      = busy_q;
    assign err_count_o = err_cnt_q;

`ifdef CORE_WB_BRIDGE_RSP_REG_EN
    logic                  rsp_ack_q, rsp_ack_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // loaded for exactly one cycle, which is the RESP state
    always_comb begin
        rsp_ack_d  = done;
        rsp_err_d  = timed_out;
        rsp_data_d = rsp_data_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ack_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            rsp_ack_q  <= rsp_ack_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_ack_o  = rsp_ack_q;
    assign rsp_err_o  = rsp_err_q;
    assign rsp_data_o = rsp_data_q;
`else
    assign rsp_ack_o  = done;
    assign rsp_err_o  = timed_out;
    assign rsp_data_o = rsp_data_w;
`endif
endmodule

// File: tb/tb_core_wb_bridge.sv
// tb_core_wb_bridge: randomized transactions against a transaction-level model of the bridge.
// Honours CORE_WB_BRIDGE_RSP_REG_EN for the extra response cycle.
module tb_core_wb_bridge;
    localparam int T = 4;
`ifdef CORE_WB_BRIDGE_RSP_REG_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_rd_i, req_wr_i;
    logic [31:0] req_addr_i, req_data_i;
    logic [3:0]  req_sel_i;
    logic        rsp_ack_o, rsp_err_o, busy_o;
    logic [31:0] rsp_data_o;
    logic [7:0]  err_count_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
    logic        wb_ack_i;

    core_wb_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_rd_i(req_rd_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_sel_i(req_sel_i),
        .rsp_ack_o(rsp_ack_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o), .err_count_o(err_count_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;
    bit e_cyc, e_busy, e_ack, e_err, e_errchk, e_we;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_sel;
    int err_model = 0;
    int cyc_seen, lat_seen;
    logic we_seen, rsp_e;
    logic [31:0] rsp_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wb_cyc", wb_cyc_o, e_cyc);
            chk("wb_stb", wb_stb_o, e_cyc);
            chk("busy", busy_o, e_busy);
            chk("rsp_ack", rsp_ack_o, e_ack);
            if (e_ack) begin
                chk("rsp_err", rsp_err_o, e_err);
                chk("rsp_data", rsp_data_o, e_rdata);
            end
            if (e_cyc) begin
                chk("wb_we", wb_we_o, e_we);
                chk("wb_addr", wb_addr_o, e_addr);
                chk("wb_data", wb_data_o, e_wdata);
                chk("wb_sel", wb_sel_o, e_sel);
            end
            if (e_errchk) chk("err_count", err_count_o, err_model);
        end
    end

    task automatic set_idle();
        e_cyc = 0; e_busy = 0; e_ack = 0; e_errchk = 1;
    endtask

    task automatic idle_cycle(input bit stray);
        req_rd_i = 0; req_wr_i = 0; wb_ack_i = stray; wb_data_i = $urandom;
        set_idle();
        @(posedge clk); #1;
        wb_ack_i = 0;
    endtask

    // kind: 0 read, 1 write, 2 both; d = wait states before ack, -1 = slave never acks
    task automatic txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel, input int d, input logic [31:0] rv);
        int a, k;
        bit err;
        a = (d < 0) ? 1000 : d + 1;
        k = (a <= T) ? a : T;
        err = a > T;
        req_rd_i = (kind != 1); req_wr_i = (kind != 0);
        req_addr_i = addr; req_data_i = wdata; req_sel_i = sel;
        wb_ack_i = 0; wb_data_i = $urandom;
        set_idle();
        e_we = (kind != 0); e_addr = addr; e_wdata = wdata; e_sel = sel; e_err = err;
        e_rdata = err ? 32'hDEADBEEF : (e_we ? 32'h0 : rv);
        cyc_seen = 0; lat_seen = 0; we_seen = 0; rsp_d = 0; rsp_e = 0;
        for (int j = 1; j <= k + M; j++) begin
            @(posedge clk); #1;
            req_addr_i = $urandom; req_data_i = $urandom; req_sel_i = 4'($urandom);
            wb_ack_i = (j == a); wb_data_i = (j == a) ? rv : $urandom;
            e_cyc = (j <= k); e_busy = 1; e_ack = (j == k + M); e_errchk = (j <= k);
            #1;
            if (wb_cyc_o) begin cyc_seen++; we_seen = wb_we_o; end
            if (rsp_ack_o && lat_seen == 0) begin lat_seen = j; rsp_d = rsp_data_o; rsp_e = rsp_err_o; end
        end
        @(posedge clk); #1;
        req_rd_i = 0; req_wr_i = 0; wb_ack_i = 0;
        if (err && err_model < 255) err_model++;
        set_idle();
    endtask

    initial begin
        int r;
        req_rd_i = 0; req_wr_i = 0; req_addr_i = 0; req_data_i = 0; req_sel_i = 0;
        wb_ack_i = 0; wb_data_i = 0;
        rst_n = 1; #1 rst_n = 0; #2;
        chk("rst_cyc", wb_cyc_o, 0);       chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);         chk("rst_sel", wb_sel_o, 0);
        chk("rst_addr", wb_addr_o, 0);     chk("rst_wdata", wb_data_o, 0);
        chk("rst_rsp_ack", rsp_ack_o, 0);  chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0); chk("rst_busy", busy_o, 0);
        chk("rst_err_count", err_count_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        set_idle(); chk_en = 1;
        idle_cycle(0);

        txn(0, 32'h100, 32'h0, 4'hF, 0, 32'h12345678);
        chk("rd_latency", lat_seen, 1 + M);
        chk("rd_data", rsp_d, 32'h12345678);
        chk("rd_cyc_len", cyc_seen, 1);
        chk("rd_we", we_seen, 0);

        wb_ack_i = 1; #1;
        chk("stray_ack", rsp_ack_o, 0);
        idle_cycle(1);
        chk("stray_busy", busy_o, 0);

        txn(1, 32'h200, 32'hCAFEF00D, 4'b0011, 3, 32'h0);
        chk("wr_cyc_len", cyc_seen, 4);
        chk("wr_we", we_seen, 1);
        chk("wr_err", rsp_e, 0);
        chk("wr_latency", lat_seen, 4 + M);
        chk("ack_at_timeout_errcnt", err_count_o, 0);

        txn(0, 32'h300, 32'h0, 4'hF, -1, 32'h0);
        chk("to_cyc_len", cyc_seen, 4);
        chk("to_err", rsp_e, 1);
        chk("to_data", rsp_d, 32'hDEADBEEF);
        chk("to_latency", lat_seen, 4 + M);
        chk("to_err_count", err_count_o, 1);

        txn(2, 32'h400, 32'h0BADF00D, 4'b1100, 1, 32'h55AA55AA);
        chk("both_we", we_seen, 1);
        chk("both_data", rsp_d, 0);

        repeat (150) begin
            if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom_range(0, 1)));
            r = $urandom_range(0, 7);
            txn($urandom_range(0, 2), $urandom, $urandom, 4'($urandom), (r == 7) ? -1 : r, $urandom);
        end

        repeat (300) txn(0, $urandom, $urandom, 4'($urandom), -1, $urandom);
        chk("err_count_sat", err_count_o, 255);

        chk_en = 0;
        req_rd_i = 1; req_addr_i = 32'h500; req_sel_i = 4'hF;
        @(posedge clk); #1;
        chk("mid_cyc_open", wb_cyc_o, 1);
        @(posedge clk); #1;
        rst_n = 0; #1;
        chk("mid_rst_cyc", wb_cyc_o, 0);
        chk("mid_rst_stb", wb_stb_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ack", rsp_ack_o, 0);
        chk("mid_rst_errcnt", err_count_o, 0);
        req_rd_i = 0;
        @(posedge clk); #1;
        chk("mid_rst_noack", rsp_ack_o, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        err_model = 0; set_idle(); chk_en = 1;
        txn(0, 32'h600, 32'h0, 4'hF, 0, 32'hA5A55A5A);
        chk("post_rst_data", rsp_d, 32'hA5A55A5A);
        chk("post_rst_latency", lat_seen, 1 + M);
        idle_cycle(0);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
